matrix_result_serializer: RTL

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

---
 rtl/matrix_result_serializer_if.sv | 35 +++
 rtl/matrix_result_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer_if.sv
// Element stream carrying one product-matrix element per beat with its
// row/column coordinates and an end-of-matrix marker.
interface matrix_result_serializer_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 3
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [IDX_W-1:0] m_row;
  logic [IDX_W-1:0] m_col;
  logic             m_last;

  // Serializer side: produces elements, observes back-pressure.
  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_col,
    output m_last,
    input  m_ready
  );

  // Consumer side.
  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_col,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/matrix_result_serializer.sv
// Captures a complete SIZE x SIZE product matrix in one cycle and replays it
// as a row-major valid/ready element stream. A new matrix is only accepted
// while idle or on the handshake of the final element; any other capture
// request is dropped and flagged on the sticky overrun_o.
module matrix_result_serializer #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 3
) (
  input  logic                               clock,
  input  logic                               nreset,
  input  logic                               res_valid_i,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] res_i,
  matrix_result_serializer_if.master         m,
  output logic                               busy_o,
  output logic                               overrun_o,
  input  logic                               clr_overrun_i
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]                         state_q, state_d;
  logic [IDX_W-1:0]                   row_q, row_d;
  logic [IDX_W-1:0]                   col_q, col_d;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0]                   data_q, data_d;
  logic                               last_q, last_d;
  logic                               overrun_q, overrun_d;

  logic streaming;
  logic hs;
  logic at_last;
  logic capture;
  logic drop;

  // Valid and busy are both the STREAM state bit, so they come straight
  // from a flop.
  assign streaming = (state_q == ST_STREAM);
  assign hs        = streaming && m.m_ready;
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  // Back-to-back matrices are accepted on the final handshake so the
  // stream continues without a bubble.
  assign capture   = res_valid_i && (!streaming || (hs && at_last));
  assign drop      = res_valid_i && !capture;

  assign m.m_valid = state_q[0];
  assign m.m_data  = data_q;
  assign m.m_row   = row_q;
  assign m.m_col   = col_q;
  assign m.m_last  = last_q;
  assign busy_o    = state_q[0];
  assign overrun_o = overrun_q;

  // Next-state: capture, advance on handshake, or retire to IDLE.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    buf_d     = buf_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q;

    if (capture) begin
      buf_d   = res_i;
      row_d   = ZERO_IDX;
      col_d   = ZERO_IDX;
      // The buffer is loading this same edge, so the first element is
      // taken from the input rather than from buf_q.
      data_d  = res_i[0][0];
      last_d  = (SIZE == 1);
      state_d = ST_STREAM;
    end else if (hs) begin
      if (at_last) begin
        state_d = ST_IDLE;
        row_d   = ZERO_IDX;
        col_d   = ZERO_IDX;
        last_d  = 1'b0;
        // data_q deliberately keeps the last streamed value while idle.
      end else begin
        if (col_q == LAST_IDX) begin
          col_d = ZERO_IDX;
          row_d = row_q + IDX_W'(1);
        end else begin
          col_d = col_q + IDX_W'(1);
        end
        data_d = buf_q[row_d][col_d];
        last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
      end
    end

    // A drop in the same cycle as a clear must still be reported.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // State, index, buffer and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      row_q     <= ZERO_IDX;
      col_q     <= ZERO_IDX;
      buf_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
